axis_shift_buffer_mc: RTL and testbench

Multi-channel, parametrised shift buffer between the input line buffer and the convolution engine. Each accepted input beat carries CHANNELS columns of UNITS+KERNEL_H_MAX-1 words. The block replays that beat as kernel_h_1+1 output beats; beat j presents the window of rows j..j+UNITS-1 for every channel. It sequences cin, column and row-block counters, and generates tlast, tuser and a done pulse.

---
 rtl/axis_shift_buffer_mc_if.sv | 30 +++
 rtl/axis_shift_buffer_mc.sv | 172 +++++++++++++++++
 tb/tb_axis_shift_buffer_mc.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/axis_shift_buffer_mc_if.sv
// Stream bundle for the shift buffer: input-line-buffer side (s_axis) and
// convolution-engine side (m_axis). master = the buffer, slave = its neighbours.
interface axis_shift_buffer_mc_if #(
   parameter int DATA_WIDTH   = 16,
   parameter int UNITS        = 8,
   parameter int CHANNELS     = 2,
   parameter int KERNEL_H_MAX = 5,
   parameter int TUSER_WIDTH  = 4
);
   localparam int IN_ROWS = UNITS + KERNEL_H_MAX - 1;

   logic [CHANNELS*IN_ROWS*DATA_WIDTH-1:0] s_axis_tdata;
   logic                                   s_axis_tvalid;
   logic                                   s_axis_tready;
   logic [CHANNELS*UNITS*DATA_WIDTH-1:0]   m_axis_tdata;
   logic                                   m_axis_tvalid;
   logic                                   m_axis_tready;
   logic                                   m_axis_tlast;
   logic [TUSER_WIDTH-1:0]                 m_axis_tuser;

   modport master (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );

   modport slave (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );
endinterface

// File: rtl/axis_shift_buffer_mc.sv
// Multi-channel shift buffer: each input beat of IN_ROWS words per channel is
// replayed as kernel_h_1+1 windows of UNITS rows, with cin/col/block sequencing.
module axis_shift_buffer_mc #(
   parameter int DATA_WIDTH   = 16,
   parameter int UNITS        = 8,
   parameter int CHANNELS     = 2,
   parameter int KERNEL_H_MAX = 5,
   parameter int KERNEL_W_MAX = 5,
   parameter int CIN_WIDTH    = 5,
   parameter int COLS_WIDTH   = 10,
   parameter int BLOCKS_WIDTH = 8,
   parameter int TUSER_WIDTH  = 4,
   localparam int KH_W        = $clog2(KERNEL_H_MAX + 1),
   localparam int KW_W        = $clog2(KERNEL_W_MAX + 1)
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    start,
   input  logic [KH_W-1:0]         kernel_h_1_in,
   input  logic [KW_W-1:0]         kernel_w_1_in,
   input  logic [CIN_WIDTH-1:0]    cin_1,
   input  logic [COLS_WIDTH-1:0]   cols_1,
   input  logic [BLOCKS_WIDTH-1:0] blocks_1,
   axis_shift_buffer_mc_if.master  axis,
   output logic [KH_W-1:0]         kernel_h_1_out,
   output logic [KW_W-1:0]         kernel_w_1_out,
   output logic                    busy,
   output logic                    done
);
   localparam int IN_ROWS = UNITS + KERNEL_H_MAX - 1;
   localparam int IN_W    = CHANNELS * IN_ROWS * DATA_WIDTH;
   localparam int OUT_W   = CHANNELS * UNITS * DATA_WIDTH;
   localparam logic [KH_W-1:0] KH_MAX_1 = KH_W'(KERNEL_H_MAX - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

   state_t                  r_state;
   logic [IN_W-1:0]         r_hold;
   logic                    r_vld;
   logic [KH_W-1:0]         r_shift;
   logic [KH_W-1:0]         r_kh;
   logic [KW_W-1:0]         r_kw;
   logic [CIN_WIDTH-1:0]    r_cin_1, r_cin, r_icin;
   logic [COLS_WIDTH-1:0]   r_cols_1, r_col, r_icol;
   logic [BLOCKS_WIDTH-1:0] r_blocks_1, r_blk, r_iblk;
   logic                    r_done;

   logic                    w_m_hs, w_wrap, w_s_rdy, w_s_hs, w_in_last;
   logic [OUT_W-1:0]        w_win;
   logic [TUSER_WIDTH-1:0]  w_user;

   assign w_m_hs    = r_vld & axis.m_axis_tready;
   assign w_wrap    = (r_shift == r_kh);
   // Reload in the same cycle the last shift beat leaves, so no bubble appears.
   assign w_s_rdy   = (r_state == S_RUN) && (!r_vld || (w_m_hs && w_wrap));
   assign w_s_hs    = w_s_rdy & axis.s_axis_tvalid;
   assign w_in_last = (r_icin == r_cin_1) && (r_icol == r_cols_1) && (r_iblk == r_blocks_1);

   always_comb begin
      w_win = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         for (int unsigned u = 0; u < UNITS; u++) begin
            w_win[(c*UNITS + u)*DATA_WIDTH +: DATA_WIDTH] =
               r_hold[(c*IN_ROWS + u + 32'(r_shift))*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      w_user    = '0;
      w_user[0] = r_vld && (r_shift == '0) && (r_cin == '0);
      w_user[1] = r_vld && (r_cin == r_cin_1);
      w_user[2] = r_vld && w_wrap;
      w_user[3] = r_vld && (r_col == r_cols_1);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state    <= S_IDLE;
         r_hold     <= '0;
         r_vld      <= 1'b0;
         r_shift    <= '0;
         r_kh       <= '0;
         r_kw       <= '0;
         r_cin_1    <= '0;
         r_cols_1   <= '0;
         r_blocks_1 <= '0;
         r_cin      <= '0;
         r_col      <= '0;
         r_blk      <= '0;
         r_icin     <= '0;
         r_icol     <= '0;
         r_iblk     <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_kh       <= (kernel_h_1_in > KH_MAX_1) ? KH_MAX_1 : kernel_h_1_in;
                  r_kw       <= kernel_w_1_in;
                  r_cin_1    <= cin_1;
                  r_cols_1   <= cols_1;
                  r_blocks_1 <= blocks_1;
                  r_cin      <= '0;
                  r_col      <= '0;
                  r_blk      <= '0;
                  r_icin     <= '0;
                  r_icol     <= '0;
                  r_iblk     <= '0;
                  r_shift    <= '0;
                  r_vld      <= 1'b0;
                  r_state    <= S_RUN;
               end
            end
            default: begin
               if (w_m_hs) begin
                  if (w_wrap) begin
                     r_shift <= '0;
                     r_vld   <= 1'b0;
                     if (r_cin == r_cin_1) begin
                        r_cin <= '0;
                        if (r_col == r_cols_1) begin
                           r_col <= '0;
                           r_blk <= r_blk + 1'b1;
                        end else begin
                           r_col <= r_col + 1'b1;
                        end
                     end else begin
                        r_cin <= r_cin + 1'b1;
                     end
                     // Only the final beat is in flight once FLUSH is entered.
                     if (r_state == S_FLUSH) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_shift <= r_shift + 1'b1;
                  end
               end
               if (w_s_hs) begin
                  r_hold  <= axis.s_axis_tdata;
                  r_vld   <= 1'b1;
                  r_shift <= '0;
                  if (r_icin == r_cin_1) begin
                     r_icin <= '0;
                     if (r_icol == r_cols_1) begin
                        r_icol <= '0;
                        r_iblk <= r_iblk + 1'b1;
                     end else begin
                        r_icol <= r_icol + 1'b1;
                     end
                  end else begin
                     r_icin <= r_icin + 1'b1;
                  end
                  if (w_in_last) r_state <= S_FLUSH;
               end
            end
         endcase
      end
   end

   assign axis.s_axis_tready = w_s_rdy;
   assign axis.m_axis_tdata  = w_win;
   assign axis.m_axis_tvalid = r_vld;
   assign axis.m_axis_tuser  = w_user;
   assign axis.m_axis_tlast  = r_vld && w_wrap && (r_cin == r_cin_1);
   assign kernel_h_1_out     = r_kh;
   assign kernel_w_1_out     = r_kw;
   assign busy               = (r_state != S_IDLE);
   assign done               = r_done;
endmodule

// File: tb/tb_axis_shift_buffer_mc.sv
// Directed bench for axis_shift_buffer_mc: a table of run configurations, each
// streamed against a beat-level model, plus a mid-run reset sequence.
module tb_axis_shift_buffer_mc;
   logic       aclk = 1'b0;
   logic       areset, start;
   logic [2:0] kh_in, kw_in, kh_out, kw_out;
   logic [4:0] cin_1;
   logic [9:0] cols_1;
   logic [7:0] blocks_1;
   logic       busy, done;

   int total = 0;
   int bad   = 0;
   int cur_case = -1;
   int cur_cyc  = 0;

   always #5 aclk = ~aclk;

   axis_shift_buffer_mc_if #(.DATA_WIDTH(16), .UNITS(8), .CHANNELS(2), .KERNEL_H_MAX(5),
                             .TUSER_WIDTH(4)) bus ();

   axis_shift_buffer_mc #(
      .DATA_WIDTH(16), .UNITS(8), .CHANNELS(2), .KERNEL_H_MAX(5), .KERNEL_W_MAX(5),
      .CIN_WIDTH(5), .COLS_WIDTH(10), .BLOCKS_WIDTH(8), .TUSER_WIDTH(4)
   ) dut (
      .aclk(aclk), .areset(areset), .start(start),
      .kernel_h_1_in(kh_in), .kernel_w_1_in(kw_in),
      .cin_1(cin_1), .cols_1(cols_1), .blocks_1(blocks_1),
      .axis(bus),
      .kernel_h_1_out(kh_out), .kernel_w_1_out(kw_out),
      .busy(busy), .done(done)
   );

   typedef struct {
      int kh_in; int kw_in; int cin1; int cols1; int blk1;
      bit bp; bit starve; bit spur;
      int exp_kh;
   } vec_t;
   vec_t tbl[5];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s case=%0d cyc=%0d: got=%0h exp=%0h", nm, cur_case, cur_cyc, act, exp);
      end
   endtask

   function automatic logic [383:0] in_beat(int k);
      logic [383:0] v;
      v = '0;
      for (int c = 0; c < 2; c++)
         for (int r = 0; r < 12; r++)
            v[(c*12 + r)*16 +: 16] = 16'(c*1000 + r*100 + k);
      return v;
   endfunction

   function automatic logic [255:0] exp_win(int k, int j);
      logic [255:0] v;
      v = '0;
      for (int c = 0; c < 2; c++)
         for (int u = 0; u < 8; u++)
            v[(c*8 + u)*16 +: 16] = 16'(c*1000 + (j + u)*100 + k);
      return v;
   endfunction

   task automatic chk_reset();
      chk("rst_tvalid", 256'(bus.m_axis_tvalid), 256'(0));
      chk("rst_tdata",  bus.m_axis_tdata,         256'(0));
      chk("rst_tlast",  256'(bus.m_axis_tlast),  256'(0));
      chk("rst_tuser",  256'(bus.m_axis_tuser),  256'(0));
      chk("rst_sready", 256'(bus.s_axis_tready), 256'(0));
      chk("rst_busy",   256'(busy),              256'(0));
      chk("rst_done",   256'(done),              256'(0));
      chk("rst_kh_out", 256'(kh_out),            256'(0));
      chk("rst_kw_out", 256'(kw_out),            256'(0));
   endtask

   task automatic run_case(input int idx, input int abort_at);
      vec_t cfg;
      int   total_in, kh, in_k, out_k, out_j, bp_cnt, st_cnt, cyc, ci, co;
      bit   exp_vld, bp_done, st_done, finished, s_hs, m_hs;
      logic exp_srdy, el;
      logic [3:0] eu;
      cfg = tbl[idx];
      cur_case = idx;
      kh = cfg.exp_kh;
      total_in = (cfg.blk1 + 1) * (cfg.cols1 + 1) * (cfg.cin1 + 1);
      @(negedge aclk);
      kh_in = 3'(cfg.kh_in); kw_in = 3'(cfg.kw_in);
      cin_1 = 5'(cfg.cin1); cols_1 = 10'(cfg.cols1); blocks_1 = 8'(cfg.blk1);
      start = 1'b1; bus.s_axis_tvalid = 1'b0; bus.m_axis_tready = 1'b1;
      @(negedge aclk);
      start = 1'b0;
      #1;
      chk("start_busy", 256'(busy), 256'(1));
      chk("kh_out", 256'(kh_out), 256'(cfg.exp_kh));
      chk("kw_out", 256'(kw_out), 256'(cfg.kw_in));
      in_k = 0; out_k = 0; out_j = 0; bp_cnt = 0; st_cnt = 0; cyc = 0;
      exp_vld = 0; bp_done = 0; st_done = 0; finished = 0;
      while (!finished && cyc < 3000) begin
         cur_cyc = cyc;
         if (cfg.bp && !bp_done && exp_vld && out_j == 1) begin
            bp_cnt = 4; bp_done = 1;
         end
         if (bp_cnt > 0) begin bus.m_axis_tready = 1'b0; bp_cnt--; end
         else bus.m_axis_tready = 1'b1;
         if (cfg.starve && !st_done && in_k == 2) begin
            st_cnt = 9; st_done = 1;
         end
         if (st_cnt > 0) begin bus.s_axis_tvalid = 1'b0; st_cnt--; end
         else bus.s_axis_tvalid = (in_k < total_in);
         bus.s_axis_tdata = in_beat(in_k);
         if (cfg.spur && cyc == 3) begin start = 1'b1; kh_in = 3'd1; end
         else begin start = 1'b0; kh_in = 3'(cfg.kh_in); end
         #1;
         chk("tvalid", 256'(bus.m_axis_tvalid), 256'(exp_vld));
         if (exp_vld) begin
            ci = out_k % (cfg.cin1 + 1);
            co = (out_k / (cfg.cin1 + 1)) % (cfg.cols1 + 1);
            eu = '0;
            eu[0] = (out_j == 0) && (ci == 0);
            eu[1] = (ci == cfg.cin1);
            eu[2] = (out_j == kh);
            eu[3] = (co == cfg.cols1);
            el = (out_j == kh) && (ci == cfg.cin1);
            chk("tdata", bus.m_axis_tdata, exp_win(out_k, out_j));
            chk("tuser", 256'(bus.m_axis_tuser), 256'(eu));
            chk("tlast", 256'(bus.m_axis_tlast), 256'(el));
         end
         exp_srdy = (in_k < total_in) && (!exp_vld || (bus.m_axis_tready && out_j == kh));
         chk("s_tready", 256'(bus.s_axis_tready), 256'(exp_srdy));
         chk("run_busy", 256'(busy), 256'(1));
         chk("run_done", 256'(done), 256'(0));
         s_hs = bus.s_axis_tvalid && exp_srdy;
         m_hs = exp_vld && bus.m_axis_tready;
         if (m_hs) begin
            if (out_j == kh) begin
               out_j = 0; out_k++; exp_vld = 0;
               if (out_k == total_in) finished = 1;
            end else out_j++;
         end
         if (s_hs) begin in_k++; exp_vld = 1; end
         cyc++;
         if (abort_at != 0 && cyc == abort_at) return;
         @(negedge aclk);
      end
      start = 1'b0; kh_in = 3'(cfg.kh_in);
      if (!finished) begin
         total++; bad++;
         $display("FAIL timeout case=%0d: got=%0d beats exp=%0d", idx, out_k, total_in);
      end
      #1;
      chk("done_pulse", 256'(done), 256'(1));
      chk("end_busy",   256'(busy), 256'(0));
      chk("end_tvalid", 256'(bus.m_axis_tvalid), 256'(0));
      chk("end_kh_out", 256'(kh_out), 256'(cfg.exp_kh));
      @(negedge aclk);
      #1;
      chk("done_clear", 256'(done), 256'(0));
   endtask

   initial begin
      //         kh kw cin cols blk bp st spur exp_kh
      tbl[0] = '{0, 1, 4, 3, 0, 0, 0, 0, 0};
      tbl[1] = '{2, 2, 0, 1, 0, 0, 0, 0, 2};
      tbl[2] = '{2, 4, 1, 1, 1, 1, 0, 0, 2};
      tbl[3] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
      tbl[4] = '{7, 3, 0, 1, 0, 0, 0, 1, 4};

      areset = 1'b1; start = 1'b0;
      kh_in = '0; kw_in = '0; cin_1 = '0; cols_1 = '0; blocks_1 = '0;
      bus.s_axis_tvalid = 1'b0; bus.s_axis_tdata = '0; bus.m_axis_tready = 1'b0;
      repeat (3) @(negedge aclk);
      #1;
      chk_reset();
      areset = 1'b0;

      for (int i = 0; i < 5; i++) run_case(i, 0);

      run_case(0, 8);
      cur_case = 99;
      areset = 1'b1;
      bus.s_axis_tvalid = 1'b0;
      @(negedge aclk);
      #1;
      chk_reset();
      areset = 1'b0;
      run_case(1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
